// File: rtl/mult_pkg.sv
// Shared definitions for the FP multiply path.
//   state_t    : sequencer states of the mantissa multiplier (2-bit encoding)
//   MANT_W     : default mantissa width including the hidden bit
//   cnt_width(): iteration-counter width for a given mantissa width
package mult_pkg;

  localparam int MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..w-1. The minimum width is 1 bit, so w=2 still
  // gets a usable counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/rca_nb.sv
// Purely combinational N-bit ripple-carry adder built from a chain of
// 1-bit full-adder cells. The carry-in is tied to 0.
// Ports:
//   x, y : N-bit addends
//   sum  : N-bit sum
//   co   : carry-out of the most significant cell
module rca_nb #(
  parameter int N = 24
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_fa
      // One full-adder cell: sum and carry from x, y and the incoming carry.
      assign sum[gi]      = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi+1]  = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign co = carry[N];

endmodule

// File: rtl/seq_mant_mult.sv
// Sequential shift-and-add unsigned mantissa multiplier.
// One partial product is accumulated per cycle on a shared W-bit
// ripple-carry adder; the 2W-bit product takes exactly W cycles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (a = multiplicand, b = multiplier)
//   out_valid, out_ready: product handshake, p = a*b (registered, held)
//   busy                : high while the product is being computed
module seq_mant_mult
  import mult_pkg::*;
#(
  parameter int W = MANT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     mcand_reg;
  logic [W-1:0]     acc_reg;
  logic [W-1:0]     q_reg;
  logic [2*W-1:0]   p_reg;

  logic [W-1:0]     addend;
  logic [W-1:0]     sum;
  logic             co;
  logic [W-1:0]     acc_next;
  logic [W-1:0]     q_next;
  logic             last_iter;
  logic             accept;

  // Partial product for this iteration is selected by the multiplier LSB.
  assign addend = q_reg[0] ? mcand_reg : '0;

  rca_nb #(.N(W)) u_adder (
    .x   (acc_reg),
    .y   (addend),
    .sum (sum),
    .co  (co)
  );

  // {acc,q} <= {co, sum, q} >> 1: the carry is kept as the new acc MSB and
  // the bit falling out of the sum moves into the top of q.
  assign acc_next  = {co, sum[W-1:1]};
  assign q_next    = {sum[0], q_reg[W-1:1]};
  assign last_iter = (cnt_reg == LAST_CNT);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      p_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        mcand_reg <= a;
        q_reg     <= b;
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end else if (state_reg == CALC) begin
        acc_reg <= acc_next;
        q_reg   <= q_next;
        if (last_iter) begin
          // Wrap explicitly: W need not be a power of two.
          cnt_reg <= '0;
          p_reg   <= {acc_next, q_next};
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign p = p_reg;

endmodule

// File: tb/tb_seq_mant_mult.sv
module tb_seq_mant_mult;

  logic clk;
  logic rst_n;

  // W=24 instance
  logic        in_valid24, in_ready24, out_valid24, out_ready24, busy24;
  logic [23:0] a24, b24;
  logic [47:0] p24;

  // W=4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int tests_run;
  int tests_failed;

  seq_mant_mult #(.W(24)) dut24 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid24), .in_ready(in_ready24), .a(a24), .b(b24),
    .out_valid(out_valid24), .out_ready(out_ready24), .p(p24), .busy(busy24)
  );

  seq_mant_mult #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .p(p4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (in_ready24 !== 1'b1 || out_valid24 !== 1'b0 || busy24 !== 1'b0 || p24 !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset24: in_ready=%b out_valid=%b busy=%b p=%h, want 1 0 0 0",
               in_ready24, out_valid24, busy24, p24);
    end
    tests_run++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || p4 !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset4: in_ready=%b out_valid=%b busy=%b p=%h, want 1 0 0 0",
               in_ready4, out_valid4, busy4, p4);
    end
    $display("[TB] reset released");
  endtask

  // One W=24 product: accept, measure latency, check p, stall `stall`
  // cycles with in_valid pulses, then release out_ready.
  task automatic run24(input logic [23:0] ta, input logic [23:0] tb, input int stall,
                       input string name);
    logic [47:0] exp_p;
    int n;
    exp_p = 48'(ta) * 48'(tb);
    out_ready24 = (stall == 0);
    n = 0;
    while (!in_ready24 && n < 100) begin tick(); n++; end
    a24 = ta; b24 = tb; in_valid24 = 1'b1;
    tick();                                  // acceptance edge k
    in_valid24 = 1'b0;
    a24 = 24'($urandom); b24 = 24'($urandom); // must have no effect now
    n = 0;
    while (!out_valid24 && n < 100) begin tick(); n++; end
    tests_run++;
    if (n != 24) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d edges, want 24", name, n);
    end
    tests_run++;
    if (p24 !== exp_p) begin
      tests_failed++;
      $display("FAIL %s product: p=%h, want %h", name, p24, exp_p);
    end
    for (int i = 0; i < stall; i++) begin
      in_valid24 = 1'b1; a24 = 24'($urandom); b24 = 24'($urandom);
      tests_run++;
      if (out_valid24 !== 1'b1 || in_ready24 !== 1'b0 || p24 !== exp_p) begin
        tests_failed++;
        $display("FAIL %s stall%0d: out_valid=%b in_ready=%b p=%h, want 1 0 %h",
                 name, i, out_valid24, in_ready24, p24, exp_p);
      end
      tick();
    end
    // Offer operands on the leaving edge: they must not be taken in DONE.
    in_valid24 = 1'b1;
    out_ready24 = 1'b1;
    tick();
    in_valid24 = 1'b0;
    out_ready24 = 1'b0;
    tests_run++;
    if (out_valid24 !== 1'b0 || in_ready24 !== 1'b1 || busy24 !== 1'b0 || p24 !== exp_p) begin
      tests_failed++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b p=%h, want 0 1 0 %h",
               name, out_valid24, in_ready24, busy24, p24, exp_p);
    end
    $display("[TB] %s a=%h b=%h p=%h latency=%0d stall=%0d", name, ta, tb, p24, n, stall);
  endtask

  task automatic test_max();
    run24(24'hFFFFFF, 24'hFFFFFF, 0, "max");
    tests_run++;
    if (p24 !== 48'hFFFFFE000001) begin
      tests_failed++;
      $display("FAIL max_const: p=%h, want fffffe000001", p24);
    end
  endtask

  task automatic test_hidden_bit();
    run24(24'h800000, 24'h800000, 0, "hidden_1x1");
    tests_run++;
    if (p24 !== 48'h400000000000) begin
      tests_failed++;
      $display("FAIL hidden_1x1_const: p=%h, want 400000000000", p24);
    end
    run24(24'hC00000, 24'hC00000, 0, "hidden_1.5x1.5");
    tests_run++;
    if (p24 !== 48'h900000000000) begin
      tests_failed++;
      $display("FAIL hidden_1.5_const: p=%h, want 900000000000", p24);
    end
  endtask

  task automatic test_zero();
    run24(24'h000000, 24'hABCDEF, 0, "zero");
  endtask

  task automatic test_backpressure();
    run24(24'h000003, 24'h000005, 10, "backpressure");
    tests_run++;
    if (p24 !== 48'h00000000000F) begin
      tests_failed++;
      $display("FAIL backpressure_const: p=%h, want 00000000000f", p24);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run24(24'($urandom), 24'($urandom), int'($urandom_range(0, 3)), "random");
  endtask

  task automatic test_reset_mid_calc();
    int n;
    out_ready24 = 1'b1;
    a24 = 24'h123456; b24 = 24'h654321; in_valid24 = 1'b1;
    tick();
    in_valid24 = 1'b0;
    repeat (10) tick();                       // counter now at 10
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready24 !== 1'b1 || out_valid24 !== 1'b0 || busy24 !== 1'b0 || p24 !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b busy=%b p=%h, want 1 0 0 0",
               in_ready24, out_valid24, busy24, p24);
    end
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid24) n++;
    end
    tests_run++;
    if (n != 0) begin
      tests_failed++;
      $display("FAIL reset_no_output: out_valid seen %0d cycles, want 0", n);
    end
    out_ready24 = 1'b0;
    $display("[TB] reset mid-calc aborted, out_valid cycles after=%0d", n);
  endtask

  task automatic test_exhaustive_w4();
    int n, nb;
    logic [7:0] exp_p;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        exp_p = 8'(ia) * 8'(ib);
        out_ready4 = 1'b0;
        n = 0;
        while (!in_ready4 && n < 50) begin tick(); n++; end
        a4 = 4'(ia); b4 = 4'(ib); in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        nb = busy4 ? 1 : 0;
        n = 0;
        while (!out_valid4 && n < 50) begin
          tick();
          n++;
          if (busy4) nb++;
        end
        tests_run++;
        if (p4 !== exp_p || n != 4) begin
          tests_failed++;
          $display("FAIL w4_product a=%0d b=%0d: p=%0d latency=%0d, want %0d latency 4",
                   ia, ib, p4, n, exp_p);
        end
        tests_run++;
        if (nb != 4) begin
          tests_failed++;
          $display("FAIL w4_busy a=%0d b=%0d: busy cycles=%0d, want 4", ia, ib, nb);
        end
        repeat ($urandom_range(0, 2)) tick();
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        $display("[TB] w4 a=%0d b=%0d p=%0d busy=%0d", ia, ib, p4, nb);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    in_valid24 = 1'b0; out_ready24 = 1'b0; a24 = '0; b24 = '0;
    in_valid4 = 1'b0;  out_ready4 = 1'b0;  a4 = '0;  b4 = '0;
    test_reset();
    test_max();
    test_hidden_bit();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_exhaustive_w4();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
